// File: rtl/timing_generator_if.sv
// Phase-sequencer bundle between the timing generator and the instruction
// controller / front panel. The generator sits on the slave modport.
interface timing_generator_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       ir_op;
    logic             mem_ready;
    logic             run;
    logic             step;
    logic [2:0]       timer;
    logic             busy;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output ir_op, mem_ready, run, step,
        input  timer, busy, instr_done, illegal, instr_count
    );

    modport slave (
        input  ir_op, mem_ready, run, step,
        output timer, busy, instr_done, illegal, instr_count
    );
endinterface

// File: rtl/timing_generator.sv
// Timing generator: drives the 3-bit phase code decoded by the instruction
// controller, selects the phase path from the IR opcode, stalls on memory
// wait states, handles run/single-step, flags illegal opcodes and counts
// retired instructions.
module timing_generator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    timing_generator_if.slave  tif
);

    // State encodings are the phase codes themselves, so timer comes
    // straight off the state register.
    typedef enum logic [2:0] {
        PH_IDLE   = 3'b100,
        PH_FETCH  = 3'b000,
        PH_IRLOAD = 3'b001,
        PH_EXEC   = 3'b011,
        PH_MADDR  = 3'b101,
        PH_MDATA  = 3'b111
    } phase_e;

    phase_e           state_q, state_d;
    logic             step_q, step_d;
    logic             instr_done_q, instr_done_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             start;
    logic             retire;

    // Memory-class opcodes 0x80..0x83 take the two extra memory phases.
    function automatic logic is_mem_op(input logic [7:0] op);
        return (op[7:2] == 6'b100000);
    endfunction

    // Opcodes that complete in the execute phase.
    function automatic logic is_single_op(input logic [7:0] op);
        return (op <= 8'h0D) || (op == 8'h40) || (op == 8'h41) ||
               ((op >= 8'h43) && (op <= 8'h47)) ||
               (op == 8'h78) || (op == 8'h7A);
    endfunction

    // Next-phase selection, retire bookkeeping and step edge detection.
    always_comb begin
        state_d      = state_q;
        step_d       = tif.step;
        instr_done_d = 1'b0;
        illegal_d    = illegal_q;
        count_d      = count_q;
        retire       = 1'b0;
        start        = tif.run | (tif.step & ~step_q);

        case (state_q)
            PH_IDLE: begin
                if (start && !illegal_q) begin
                    state_d = PH_FETCH;
                end
            end
            PH_FETCH: begin
                state_d = PH_IRLOAD;
            end
            PH_IRLOAD: begin
                if (tif.mem_ready) begin
                    state_d = PH_EXEC;
                end
            end
            PH_EXEC: begin
                if (is_mem_op(tif.ir_op)) begin
                    state_d = PH_MADDR;
                end else if (is_single_op(tif.ir_op)) begin
                    retire = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = PH_IDLE;
                end
            end
            PH_MADDR: begin
                state_d = PH_MDATA;
            end
            PH_MDATA: begin
                if (tif.mem_ready) begin
                    retire = 1'b1;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase

        // run is re-sampled here so a step edge seen mid-instruction never
        // chains a second instruction.
        if (retire) begin
            count_d      = count_q + CNT_W'(1);
            instr_done_d = 1'b1;
            state_d      = tif.run ? PH_FETCH : PH_IDLE;
        end
    end

    // State registers; step_q resets high so a button held through reset
    // does not count as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= PH_IDLE;
            step_q       <= 1'b1;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            instr_done_q <= instr_done_d;
            illegal_q    <= illegal_d;
            count_q      <= count_d;
        end
    end

    assign tif.timer       = state_q;
    assign tif.busy        = (state_q != PH_IDLE);
    assign tif.instr_done  = instr_done_q;
    assign tif.illegal     = illegal_q;
    assign tif.instr_count = count_q;

endmodule

// File: doc/timing_generator.md
Name: timing_generator

Overview:
- Phase sequencer directly upstream of the instruction controller. It drives the 3-bit `timer` phase code that the controller decodes: 100 idle, 000 fetch-address, 001 IR-load, 011 execute, 101 memory-address, 111 memory-data.
- Chooses the per-instruction phase path from the opcode byte held in IR.
- Stalls on memory wait states, supports run/single-step control, detects illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- ir_op  input  8  IR[15:8]; valid from the first cycle of phase 011 onward.
- mem_ready  input  1  memory handshake; 1 = the access in the current phase completes this cycle.
- run  input  1  level; 1 = execute instructions continuously.
- step  input  1  raw level from the button; its rising edge requests one instruction.
- timer  output  3  phase code to the controller.
- busy  output  1  1 whenever timer != 100.
- instr_done  output  1  one-cycle pulse, registered, the cycle after an instruction retires.
- illegal  output  1  sticky; set by an undecodable opcode.
- instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- All state is held in registers and timer is driven directly from a register.
- Reset (rst_n=0 at an edge) takes effect from any phase, including mid-instruction. It sets:
  - timer=100, busy=0, instr_done=0, illegal=0, instr_count=0;
  - internal step_q=1, so a button already held through reset does not trigger.
- start = run | (step & ~step_q). step_q <= step every cycle.
- Phase 100 (IDLE):
  - Go to 000 if start=1 and illegal=0; otherwise stay in 100.
  - When illegal=1, run and step are ignored until reset.
- Phase 000: unconditionally go to 001. The controller latches PC into AR and increments PC here.
- Phase 001:
  - Stay in 001 while mem_ready=0; this is the IR-load wait.
  - Go to 011 when mem_ready=1.
- Phase 011 decodes ir_op:
  - Memory class 0x80–0x83 -> 101.
  - Legal single-phase opcodes retire: 0x00–0x0D, 0x40, 0x41, 0x43–0x47, 0x78, 0x7A.
  - Any other value, including 0x0E–0x3F, 0x42 and 0x84 and above: illegal <= 1, timer -> 100, no retire, no instr_done, no count increment.
- Phase 101: unconditionally go to 111.
- Phase 111: stay in 111 while mem_ready=0; retire when mem_ready=1.
- Retire:
  - instr_count <= instr_count+1, wrapping modulo 2^CNT_W (0xFFFF -> 0x0000 at the default width).
  - instr_done <= 1 for exactly one cycle.
  - Next phase is 000 if run=1 at the retire edge, otherwise 100. A step edge during an instruction does not chain a second instruction.
- run is sampled only in 100 and at retire. Dropping run mid-instruction always completes the current instruction.
- run=1 together with a step edge in 100: a single start; no extra step is queued.
- Latency:
  - ALU/branch instruction: 3 cycles (000, 001, 011).
  - Memory instruction: 5 cycles.
  - Each mem_ready=0 cycle in 001 or 111 adds one cycle.
- mem_ready is ignored in phases 100, 000, 011 and 101.
- Phase codes 010 and 110 are never produced. If ever reached (e.g. SEU), next state is 100 with no side effects.

Test Plan:
- Reset then run=1, ir_op=0x00, mem_ready=1: timer sequence 100,000,001,011,000,001,011…; instr_done pulses every 3 cycles; instr_count=3 after 9 cycles in 000.
- run=0, step pulse (0->1, held 5 cycles), ir_op=0x82, mem_ready=1: timer 100,000,001,011,101,111,100 and stays in 100; instr_count=1; a single instr_done pulse.
- run=1, ir_op=0x80, mem_ready low for 2 cycles in 001 and 3 cycles in 111: instruction takes 10 cycles; timer holds 001 twice and 111 three times as extra cycles; count +1.
- ir_op=0x42 at 011 with run=1: illegal=1, timer=100 next cycle; count unchanged; later step edges and run=1 leave timer=100; rst_n=0 clears illegal.
- rst_n=0 for one edge while timer=111 with mem_ready=0: next timer=100 and count=0; with step held high through reset, no start after reset until step goes 0 then 1.
- CNT_W=4, run=1, ir_op=0x01: after 16 retirements instr_count wraps 0xF -> 0x0; instr_done is still pulsed.
